pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage of the 8-bit datapath; consumes the
//  2-bit PC-select produced by the branch/jump decision unit (00 seq, 01 branch, 10 jump).
//  Holds the PC, fetches from instruction memory over a req/ack handshake, and presents
//  one instruction at a time to decode over valid/ready. Redirects flush stale fetches.
// PARAMETERS
//  IW        16        instruction width in bits
//  RESET_PC  8'h00     PC value loaded on reset
// PORTS
//  clk             in   1    clock, rising edge
//  rst_n           in   1    asynchronous reset, active-low
//  redirect_valid  in   1    qualifies pc_sel/br_offset/jmp_target this cycle
//  pc_sel          in   2    00 sequential, 01 branch taken, 10 jump, 11 reserved
//  br_offset       in   8    sign-extended branch offset (two's complement)
//  jmp_target      in   8    absolute jump address
//  imem_req        out  1    fetch request to instruction memory
//  imem_addr       out  8    fetch address; stable while imem_req high and no ack
//  imem_ack        in   1    memory completes request at this edge; imem_rdata valid
//  imem_rdata      in   IW   fetched instruction word
//  inst_valid      out  1    inst_out/inst_pc valid for decode
//  inst_ready      in   1    decode accepts instruction at this edge
//  inst_out        out  IW   instruction to decode
//  inst_pc         out  8    address of inst_out
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC,
//    inst_valid=0, inst_out=0, inst_pc=0, last_pc=RESET_PC.
//  - States: IDLE -> FETCH unconditionally on first edge after reset release.
//    FETCH: imem_req=1, imem_addr=pc. On imem_ack: if drop=0 latch imem_rdata->inst_out,
//    pc->inst_pc, pc<=pc+1, go HOLD; if drop=1 discard data, clear drop, stay FETCH at pc.
//    HOLD: inst_valid=1, imem_req=0. On inst_ready: last_pc<=inst_pc, go FETCH.
//  - Throughput: 1 instruction per 2 cycles with zero-wait memory; fetch latency from
//    FETCH entry = imem ack latency + 1 edge to inst_valid.
//  - Redirect applies only when redirect_valid=1 and pc_sel in {01,10}; 00 and 11 no-op.
//    Target: 01 -> last_pc + 1 + br_offset; 10 -> jmp_target. All PC arithmetic mod 256
//    (8-bit wrap: 8'hFF + 1 = 8'h00; 8'h02 + 1 + 8'hFC = 8'hFF).
//    If inst_ready coincides in HOLD, last_pc updates same edge but target uses the old last_pc.
//  - Redirect in IDLE: pc<=target, go FETCH.
//  - Redirect in FETCH with imem_ack same edge: returned data discarded, pc<=target, stay FETCH
//    (new request issued next cycle).
//  - Redirect in FETCH without ack: outstanding request not abandoned (addr held stable);
//    pc<=target, drop<=1; data of that ack discarded, then fetch from target.
//  - Redirect in HOLD: inst_valid<=0 next cycle (held instruction flushed whether or not
//    inst_ready is high), pc<=target, go FETCH.
//  - Second redirect while drop=1: pc updates to newest target; drop stays 1 (one discard only).
//  - imem_ack while imem_req=0 is ignored. inst_ready while inst_valid=0 ignored.
//  - inst_out/inst_pc stable while inst_valid=1 and not accepted.
// STRUCTURE
//  - Shared package: PC_SEL_SEQ=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JUMP=2'b10 (shared with the
//    branch decision unit); FSM state encodings ST_IDLE/ST_FETCH/ST_HOLD; PC width 8.
//  - Sub-module pc_next_calc: combinational target selection (last_pc+1+br_offset vs jmp_target).
//  - Top: FSM, pc/last_pc/drop registers, output registers.
// TESTING
//  1 Reset, zero-wait ack every req -> imem_addr 00,01,02 on successive FETCH cycles; inst_pc matches.
//  2 Memory acks after 3 cycles -> imem_addr stays 05 for all 3 wait cycles; inst_valid 1 edge after ack.
//  3 Deliver inst_pc=02, then redirect pc_sel=01, br_offset=8'hFC -> next imem_addr=8'hFF, then 8'h00.
//  4 Jump jmp_target=8'h40 while FETCH at 07 pending -> ack for 07 discarded, inst_valid stays 0,
//    next imem_addr=8'h40, first delivered inst_pc=8'h40.
//  5 HOLD with inst_ready=0, redirect jump 8'h10 -> inst_valid drops next cycle; pc_sel=11 or 00 with
//    redirect_valid=1 -> no PC change.
//  6 rst_n low mid-FETCH (imem_req=1) -> imem_req, inst_valid 0 immediately; resumes at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared PC-select codes, fetch FSM states and PC width
// Purpose: constants shared by the fetch unit and the branch decision unit.
// Ports: none (package).
package pc_fetch_unit_pkg;

    localparam int PC_W = 8;

    // PC-select codes produced by the branch/jump decision unit
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    // Only branch-taken and jump move the PC; sequential and the reserved code are no-ops
    function automatic logic is_redirect_sel(input logic [1:0] sel);
        return (sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// rtl/pc_fetch_unit_next_calc.sv - combinational redirect target selection
// Purpose: decides whether a redirect applies and computes its target address.
// Ports:
//   redirect_valid_i  qualifies pc_sel_i/br_offset_i/jmp_target_i
//   pc_sel_i          PC-select code
//   last_pc_i         address of the last instruction accepted by decode
//   br_offset_i       two's-complement branch offset
//   jmp_target_i      absolute jump address
//   redirect_o        a redirect applies this cycle
//   target_o          redirect target address
module pc_next_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic            redirect_valid_i,
    input  logic [1:0]      pc_sel_i,
    input  logic [PC_W-1:0] last_pc_i,
    input  logic [PC_W-1:0] br_offset_i,
    input  logic [PC_W-1:0] jmp_target_i,
    output logic            redirect_o,
    output logic [PC_W-1:0] target_o
);

    always_comb begin
        redirect_o = redirect_valid_i && is_redirect_sel(pc_sel_i);
        // 8-bit add wraps naturally, giving the mod-256 branch target
        if (pc_sel_i == PC_SEL_JUMP) begin
            target_o = jmp_target_i;
        end else begin
            target_o = last_pc_i + PC_W'(1) + br_offset_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch stage
// Purpose: holds the PC, fetches over a req/ack memory handshake and hands one
//   instruction at a time to decode over valid/ready; redirects flush stale fetches.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   redirect_valid, pc_sel,         redirect request from the branch decision unit
//   br_offset, jmp_target
//   imem_req, imem_addr             fetch request / address to instruction memory
//   imem_ack, imem_rdata            fetch completion / returned word
//   inst_valid, inst_ready          handshake to decode
//   inst_out, inst_pc               instruction and its address
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              IW       = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [1:0]      pc_sel,
    input  logic [PC_W-1:0] br_offset,
    input  logic [PC_W-1:0] jmp_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [IW-1:0]   inst_out,
    output logic [PC_W-1:0] inst_pc
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            drop_q, drop_d;
    // Address of the request still in flight when a redirect arrived without an ack
    logic [PC_W-1:0] addr_q, addr_d;
    logic [IW-1:0]   inst_data_q, inst_data_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;

    logic            redirect;
    logic [PC_W-1:0] target;

    pc_next_calc u_next_calc (
        .redirect_valid_i (redirect_valid),
        .pc_sel_i         (pc_sel),
        .last_pc_i        (last_pc_q),
        .br_offset_i      (br_offset),
        .jmp_target_i     (jmp_target),
        .redirect_o       (redirect),
        .target_o         (target)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            last_pc_q   <= RESET_PC;
            drop_q      <= 1'b0;
            addr_q      <= RESET_PC;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            last_pc_q   <= last_pc_d;
            drop_q      <= drop_d;
            addr_q      <= addr_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_pc_d   = last_pc_q;
        drop_d      = drop_q;
        addr_d      = addr_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d = target;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word is stale; next request goes to the target
                        pc_d   = target;
                        drop_d = 1'b0;
                    end else if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        inst_data_d = imem_rdata;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + PC_W'(1);
                        state_d     = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Keep the in-flight address on the bus; only the first
                    // redirect captures it, later ones just move the PC
                    pc_d   = target;
                    drop_d = 1'b1;
                    if (!drop_q) begin
                        addr_d = pc_q;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    last_pc_d = inst_pc_q;
                end
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (inst_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_req   = (state_q == ST_FETCH);
        inst_valid = (state_q == ST_HOLD);
        imem_addr  = drop_q ? addr_q : pc_q;
        inst_out   = inst_data_q;
        inst_pc    = inst_pc_q;
    end

endmodule
